seq_div: RTL and testbench

//  Multi-cycle restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.

---
 rtl/seq_div.sv | 182 ++++++++++++++++++
 tb/tb_seq_div.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// Multi-cycle restoring divider with start/ready handshake and fixed WIDTH+2 cycle latency.
// Define SIGNED_DIV_EN for two's-complement operands; default build is unsigned.
module seq_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

`ifdef SIGNED_DIV_EN
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction
`endif

  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             div_by_zero_q, div_by_zero_d;
`ifdef SIGNED_DIV_EN
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
`endif

  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Trial subtraction of the divisor from the left-shifted partial remainder.
  always_comb begin
    trial = {r_q, q_q[WIDTH-1]} - {2'b00, d_q};
  end

  // Operand magnitudes at load and sign correction of the raw result at FIX.
  always_comb begin
`ifdef SIGNED_DIV_EN
    a_mag = dividend[WIDTH-1] ? negate(dividend) : dividend;
    b_mag = divisor[WIDTH-1]  ? negate(divisor)  : divisor;
    q_fix = (a_neg_q ^ b_neg_q) ? negate(q_q) : q_q;
    r_fix = a_neg_q ? negate(r_q[WIDTH-1:0]) : r_q[WIDTH-1:0];
`else
    a_mag = dividend;
    b_mag = divisor;
    q_fix = q_q;
    r_fix = r_q[WIDTH-1:0];
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    q_d           = q_q;
    d_d           = d_q;
    count_d       = count_q;
    dz_d          = dz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
`ifdef SIGNED_DIV_EN
    a_neg_d       = a_neg_q;
    b_neg_d       = b_neg_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_RUN;
          r_d           = {(WIDTH+1){1'b0}};
          q_d           = a_mag;
          d_d           = b_mag;
          count_d       = {CW{1'b0}};
          dz_d          = (divisor == {WIDTH{1'b0}});
          div_by_zero_d = 1'b0;
`ifdef SIGNED_DIV_EN
          a_neg_d       = dividend[WIDTH-1];
          b_neg_d       = divisor[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (trial[WIDTH+1]) begin
          r_d = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end else begin
          r_d = trial[WIDTH:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH-1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX: begin
        // With a zero divisor every step succeeds, so R ends up holding |dividend|
        // and r_fix already reproduces the raw dividend bits.
        quotient_d    = dz_q ? {WIDTH{1'b1}} : q_fix;
        remainder_d   = r_fix;
        div_by_zero_d = dz_q;
        state_d       = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      r_q           <= {(WIDTH+1){1'b0}};
      q_q           <= {WIDTH{1'b0}};
      d_q           <= {WIDTH{1'b0}};
      count_q       <= {CW{1'b0}};
      dz_q          <= 1'b0;
      quotient_q    <= {WIDTH{1'b0}};
      remainder_q   <= {WIDTH{1'b0}};
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
`ifdef SIGNED_DIV_EN
      a_neg_q       <= 1'b0;
      b_neg_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      q_q           <= q_d;
      d_q           <= d_d;
      count_q       <= count_d;
      dz_q          <= dz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
`ifdef SIGNED_DIV_EN
      a_neg_q       <= a_neg_d;
      b_neg_q       <= b_neg_d;
`endif
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign ready       = ready_q;
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: arithmetic reference model plus a cycle-level
// handshake timeline, compared every cycle, and directed literal checks.
module tb_seq_div;
  localparam int W = 16;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         ready, done, div_by_zero;

  int checks = 0;
  int failures = 0;

  seq_div #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .ready(ready), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {div_by_zero, quotient, remainder} from plain arithmetic.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef SIGNED_DIV_EN
    if (a == 16'h8000 && b == 16'hFFFF) return {1'b0, 16'h8000, 16'h0000};
    q = sa / sb;
    r = sa % sb;
`else
    q = a / b;
    r = a % b;
`endif
    return {1'b0, q, r};
  endfunction

  // Timeline model: cnt is the cycle number since the accepted start (0 = idle).
  int           cnt = 0;
  logic         mvalid = 1'b0;
  logic [2*W:0] pres = '0;
  logic [W-1:0] eq = '0, er = '0;
  logic         edz = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0; eq <= '0; er <= '0; edz <= 1'b0; mvalid <= 1'b1;
    end else if (start && (cnt == 0 || cnt == LAT)) begin
      pres <= model(dividend, divisor);
      cnt  <= 1;
      edz  <= 1'b0;
    end else if (cnt == LAT) begin
      cnt <= 0;
    end else if (cnt != 0) begin
      cnt <= cnt + 1;
      if (cnt + 1 == LAT) begin
        eq  <= pres[2*W-1:W];
        er  <= pres[W-1:0];
        edz <= pres[2*W];
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("ready", ready, (cnt == 0 || cnt == LAT));
      chk("done", done, (cnt == LAT));
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      chk("div_by_zero", div_by_zero, edz);
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int busy);
    lat  = lat0;
    busy = 0;
    while (!done && lat < 40) begin
      if (!ready) busy++;
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h8000;
      4: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  int lat, busy, pulses;

  initial begin
    chk("model_100_7", model(16'd100, 16'd7), {1'b0, 16'd14, 16'd2});
    chk("model_div0", model(16'h1234, 16'h0000), {1'b1, 16'hFFFF, 16'h1234});
    chk("model_0_5", model(16'd0, 16'd5), {1'b0, 16'd0, 16'd0});
`ifdef SIGNED_DIV_EN
    chk("model_m7_2", model(16'hFFF9, 16'd2), {1'b0, 16'hFFFD, 16'hFFFF});
    chk("model_7_m2", model(16'd7, 16'hFFFE), {1'b0, 16'hFFFD, 16'h0001});
    chk("model_min_m1", model(16'h8000, 16'hFFFF), {1'b0, 16'h8000, 16'h0000});
`endif

    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_quotient", quotient, 16'h0000);
    chk("rst_dbz", div_by_zero, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic unsigned divide and handshake timing
    start_op(16'd100, 16'd7);
    wait_done(1, lat, busy);
    chk("t2_latency", lat, LAT);
    chk("t2_busy_cycles", busy, LAT - 1);
    chk("t2_quotient", quotient, 16'd14);
    chk("t2_remainder", remainder, 16'd2);
    @(negedge clk);

    // Zero divisor, then flag clears on the next accepted start
    start_op(16'h1234, 16'h0000);
    wait_done(1, lat, busy);
    chk("t3_latency", lat, LAT);
    chk("t3_quotient", quotient, 16'hFFFF);
    chk("t3_remainder", remainder, 16'h1234);
    chk("t3_dbz", div_by_zero, 1'b1);
    @(negedge clk);
    start_op(16'd1000, 16'd10);
    chk("t3_dbz_clear", div_by_zero, 1'b0);
    wait_done(1, lat, busy);
    chk("t3_next_quotient", quotient, 16'd100);

    // Reset in the middle of RUN aborts with no done pulse
    @(negedge clk);
    start_op(16'd500, 16'd3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_quotient", quotient, 16'h0000);
    chk("t1_ready", ready, 1'b1);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("t1_no_done", pulses, 0);

    // Starts while busy are ignored; start on DONE is accepted
    start_op(16'd1000, 16'd33);
    repeat (3) @(negedge clk);
    start_op(16'd9, 16'd3);
    repeat (4) @(negedge clk);
    start_op(16'd9, 16'd3);
    wait_done(10, lat, busy);
    chk("t5_latency", lat, LAT);
    chk("t5_quotient", quotient, 16'd30);
    chk("t5_remainder", remainder, 16'd10);
    start_op(16'd200, 16'd9);
    chk("t5_hold_quotient", quotient, 16'd30);
    wait_done(1, lat, busy);
    chk("t5_b2b_latency", lat, LAT);
    chk("t5_b2b_quotient", quotient, 16'd22);
    chk("t5_b2b_remainder", remainder, 16'd2);

`ifdef SIGNED_DIV_EN
    start_op(16'hFFF9, 16'd2);
    wait_done(1, lat, busy);
    chk("t4_m7_2_q", quotient, 16'hFFFD);
    chk("t4_m7_2_r", remainder, 16'hFFFF);
    start_op(16'd7, 16'hFFFE);
    wait_done(1, lat, busy);
    chk("t4_7_m2_q", quotient, 16'hFFFD);
    chk("t4_7_m2_r", remainder, 16'h0001);
    start_op(16'h8000, 16'hFFFF);
    wait_done(1, lat, busy);
    chk("t4_min_m1_q", quotient, 16'h8000);
    chk("t4_min_m1_r", remainder, 16'h0000);
`endif

    // Random operands with corner values, checked by the per-cycle compare
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      start_op(pick(), pick());
      wait_done(1, lat, busy);
      chk("rand_latency", lat, LAT);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
